// File: rtl/mux_8_1_if.sv
// Bundles the data inputs, select code and both outputs of the 8-to-1 mux.
// The master side drives data/selects; the slave (the mux) drives y and y_q.
interface mux_8_1_if;
    logic i0;
    logic i1;
    logic i2;
    logic i3;
    logic i4;
    logic i5;
    logic i6;
    logic i7;
    logic s0;
    logic s1;
    logic s2;
    logic y;
    logic y_q;

    modport master (
        output i0, i1, i2, i3, i4, i5, i6, i7,
        output s0, s1, s2,
        input  y, y_q
    );

    modport slave (
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        input  s0, s1, s2,
        output y, y_q
    );
endinterface

// File: rtl/mux_8_1.sv
// Single-bit 8-to-1 mux: two 4-to-1 stages plus a final 2-to-1, with a y_q register.
// Macro MUX_8_1_OUT_REG_EN adds a flop on y, making y_q a second register stage.
module mux_4_1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);
    // Nested conditionals merge agreeing candidates when a select bit is X/Z.
    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

module mux_8_1 (
    input logic      clk,
    input logic      rst_n,
    mux_8_1_if.slave bus
);
    logic y_lo;
    logic y_hi;
    logic y_comb;
    logic y_int;
    logic y_out_d;
    logic y_out_q;

    mux_4_1 u_mux_lo (
        .d0  (bus.i0),
        .d1  (bus.i1),
        .d2  (bus.i2),
        .d3  (bus.i3),
        .sel ({bus.s1, bus.s0}),
        .y   (y_lo)
    );

    mux_4_1 u_mux_hi (
        .d0  (bus.i4),
        .d1  (bus.i5),
        .d2  (bus.i6),
        .d3  (bus.i7),
        .sel ({bus.s1, bus.s0}),
        .y   (y_hi)
    );

    assign y_comb = bus.s2 ? y_hi : y_lo;

`ifdef MUX_8_1_OUT_REG_EN
    logic y_stage_d;
    logic y_stage_q;

    always_comb begin
        y_stage_d = y_comb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_stage_q <= 1'b0;
        end else begin
            y_stage_q <= y_stage_d;
        end
    end

    assign y_int = y_stage_q;
`else
    assign y_int = y_comb;
`endif

    always_comb begin
        y_out_d = y_int;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out_q <= 1'b0;
        end else begin
            y_out_q <= y_out_d;
        end
    end

    assign bus.y   = y_int;
    assign bus.y_q = y_out_q;
endmodule

// File: tb/tb_mux_8_1.sv
// Scoreboard bench for mux_8_1: stimulus queues applied input sets, a monitor
// checks y and y_q after every rising edge against data[sel].
module tb_mux_8_1;
    logic clk;
    logic rst_n;

    mux_8_1_if bus ();

    mux_8_1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] sel;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_mux(input logic [7:0] data, input logic [2:0] sel);
        return data[sel];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] data, input logic [2:0] sel);
        bus.i0 = data[0]; bus.i1 = data[1]; bus.i2 = data[2]; bus.i3 = data[3];
        bus.i4 = data[4]; bus.i5 = data[5]; bus.i6 = data[6]; bus.i7 = data[7];
        bus.s0 = sel[0];  bus.s1 = sel[1];  bus.s2 = sel[2];
    endtask

    // One input set per cycle, applied on the falling edge.
    task automatic apply(input logic [7:0] data, input logic [2:0] sel);
        item_t it;
        @(negedge clk);
        drive(data, sel);
        it.data = data;
        it.sel  = sel;
        sb_q.push_back(it);
`ifndef MUX_8_1_OUT_REG_EN
        #1;
        check("y_comb_zero_latency", bus.y, ref_mux(data, sel));
`endif
    endtask

    // Monitor: y_prev_exp is the value y held before the current edge.
    initial begin : monitor
        item_t it;
        logic  exp_now;
        logic  y_prev_exp;
        y_prev_exp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                y_prev_exp = 1'b0;
            end else if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                exp_now = ref_mux(it.data, it.sel);
`ifdef MUX_8_1_OUT_REG_EN
                check("y_reg", bus.y, exp_now);
                check("y_q_two_stage", bus.y_q, y_prev_exp);
                y_prev_exp = exp_now;
`else
                check("y_comb", bus.y, exp_now);
                check("y_q_one_stage", bus.y_q, exp_now);
                y_prev_exp = exp_now;
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        logic [7:0] pat;
        rst_n = 1'b0;
        drive(8'h00, 3'd0);
        #2;
        check("reset_y_q", bus.y_q, 1'b0);
`ifdef MUX_8_1_OUT_REG_EN
        check("reset_y", bus.y, 1'b0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // i0..i7 = 0,1,0,1,0,0,0,1 swept over every select code
        pat = 8'b1000_1010;
        for (int s = 0; s < 8; s++) apply(pat, 3'(s));

        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) apply(8'(1 << k), 3'(s));
        end

        // sel=5 held: only i5 should move y
        apply(8'h00, 3'd5);
        apply(8'h20, 3'd5);
        apply(8'h00, 3'd5);
        for (int k = 0; k < 8; k++) begin
            if (k != 5) apply(8'(1 << k), 3'd5);
        end
        apply(8'hDF, 3'd5);

        // registered path then asynchronous reset mid-cycle
        apply(8'h08, 3'd3);
        apply(8'h00, 3'd3);
        apply(8'h08, 3'd3);
        apply(8'h08, 3'd3);
        @(posedge clk);
        #3;
        check("pre_reset_y_q", bus.y_q, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_y_q", bus.y_q, 1'b0);
`ifdef MUX_8_1_OUT_REG_EN
        check("async_reset_y", bus.y, 1'b0);
`endif
        repeat (2) begin
            @(posedge clk);
            #1;
            check("held_reset_y_q", bus.y_q, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{data: 8'h08, sel: 3'd3});
        apply(8'h08, 3'd3);

        for (int n = 0; n < 200; n++) begin
            apply(8'($urandom), 3'($urandom_range(0, 7)));
        end

        for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
